// File: rtl/io_int_controller_pkg.sv
// rtl/io_int_controller_pkg.sv - shared widths and FSM encoding for the interrupt controller
package io_int_pkg;

  localparam int DATA_W = 16;
  localparam int ID_W   = 3;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SELECT   = 3'd1,
    S_ASSERT   = 3'd2,
    S_WAIT_ISR = 3'd3,
    S_GAP      = 3'd4
  } state_e;

endpackage

// File: rtl/io_int_controller_irq_edge_capture.sv
// rtl/io_int_controller_irq_edge_capture.sv - per-source rising-edge capture with data latch and overrun flag
module irq_edge_capture
  import io_int_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              req_i,
  input  logic              clr_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              pending_o,
  output logic              overrun_o,
  output logic [DATA_W-1:0] data_o
);

  logic              prev_q;
  logic              pend_q;
  logic              ovr_q;
  logic [DATA_W-1:0] data_q;
  logic              rise;

  assign rise = req_i & ~prev_q;

  // A rise coinciding with the selection clear is a fresh request, not an overrun.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_q <= 1'b0;
      pend_q <= 1'b0;
      ovr_q  <= 1'b0;
      data_q <= '0;
    end else begin
      prev_q <= req_i;
      if (rise && (!pend_q || clr_i)) begin
        pend_q <= 1'b1;
        data_q <= data_i;
      end else if (clr_i) begin
        pend_q <= 1'b0;
      end
      if (clr_i) begin
        ovr_q <= 1'b0;
      end else if (rise && pend_q) begin
        ovr_q <= 1'b1;
      end
    end
  end

  assign pending_o = pend_q;
  assign overrun_o = ovr_q;
  assign data_o    = data_q;

endmodule

// File: rtl/io_int_controller.sv
// rtl/io_int_controller.sv - prioritised interrupt requester driving the CPU int line and In_Port
module io_int_controller
  import io_int_pkg::*;
#(
  parameter int NUM_SRC   = 4,
  parameter int INT_PULSE = 2,
  parameter int GAP_CYC   = 1,
  parameter int TIMEOUT   = 255
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_SRC-1:0]        irq_req,
  input  logic [NUM_SRC-1:0]        irq_mask,
  input  logic [DATA_W*NUM_SRC-1:0] src_data,
  input  logic                      rti_done,
  output logic                      int_o,
  output logic [DATA_W-1:0]         In_Port,
  output logic [ID_W-1:0]           active_id,
  output logic                      busy,
  output logic [NUM_SRC-1:0]        pending,
  output logic [NUM_SRC-1:0]        overrun,
  output logic                      timeout_err
);

  localparam int CNT_W = 16;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              int_q, int_d;
  logic              timeout_q, timeout_d;
  logic [DATA_W-1:0] in_port_q, in_port_d;
  logic [ID_W-1:0]   active_id_q, active_id_d;

  logic [NUM_SRC-1:0] eligible;
  logic [NUM_SRC-1:0] clr;
  logic [DATA_W-1:0]  data_arr [NUM_SRC];
  logic [ID_W-1:0]    sel_id;
  logic [DATA_W-1:0]  sel_data;

  assign eligible = pending & irq_mask;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    // The selected source is released on the cycle the FSM leaves SELECT.
    assign clr[g] = (state_q == S_SELECT) && (|eligible) && (sel_id == ID_W'(g));

    irq_edge_capture u_cap (
      .clk       (clk),
      .reset     (reset),
      .req_i     (irq_req[g]),
      .clr_i     (clr[g]),
      .data_i    (src_data[DATA_W*g +: DATA_W]),
      .pending_o (pending[g]),
      .overrun_o (overrun[g]),
      .data_o    (data_arr[g])
    );
  end

  // Priority encoder: lowest eligible index wins, data word muxed alongside.
  always_comb begin
    sel_id   = '0;
    sel_data = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        sel_id   = ID_W'(i);
        sel_data = data_arr[i];
      end
    end
  end

  // Next-state and registered-output logic; SELECT re-picks so late higher-priority edges win.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    in_port_d   = in_port_q;
    active_id_d = active_id_q;
    timeout_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (|eligible) begin
          state_d     = S_SELECT;
          active_id_d = sel_id;
          in_port_d   = sel_data;
        end
      end
      S_SELECT: begin
        if (|eligible) begin
          state_d     = S_ASSERT;
          cnt_d       = '0;
          active_id_d = sel_id;
          in_port_d   = sel_data;
        end else begin
          state_d   = S_IDLE;
          in_port_d = '0;
        end
      end
      S_ASSERT: begin
        if (cnt_q == CNT_W'(INT_PULSE - 1)) begin
          state_d = S_WAIT_ISR;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WAIT_ISR: begin
        if (rti_done) begin
          state_d   = S_GAP;
          cnt_d     = '0;
          in_port_d = '0;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d   = S_GAP;
          cnt_d     = '0;
          in_port_d = '0;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_GAP: begin
        if (cnt_q == CNT_W'(GAP_CYC - 1)) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
    int_d = (state_d == S_ASSERT);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      int_q       <= 1'b0;
      timeout_q   <= 1'b0;
      in_port_q   <= '0;
      active_id_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      int_q       <= int_d;
      timeout_q   <= timeout_d;
      in_port_q   <= in_port_d;
      active_id_q <= active_id_d;
    end
  end

  assign int_o       = int_q;
  assign In_Port     = in_port_q;
  assign active_id   = active_id_q;
  assign busy        = (state_q != S_IDLE);
  assign timeout_err = timeout_q;

endmodule

// File: tb/tb_io_int_controller.sv
// tb/tb_io_int_controller.sv - self-checking bench for io_int_controller
module tb_io_int_controller;

  localparam int NS = 4;
  localparam int P  = 2;
  localparam int G  = 1;
  localparam int TO = 8;

  logic            clk = 1'b0;
  logic            reset;
  logic [NS-1:0]   irq_req;
  logic [NS-1:0]   irq_mask;
  logic [16*NS-1:0] src_data;
  logic            rti_done;
  logic            int_o;
  logic [15:0]     In_Port;
  logic [2:0]      active_id;
  logic            busy;
  logic [NS-1:0]   pending;
  logic [NS-1:0]   overrun;
  logic            timeout_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  io_int_controller #(.NUM_SRC(NS), .INT_PULSE(P), .GAP_CYC(G), .TIMEOUT(TO)) dut (
    .clk         (clk),
    .reset       (reset),
    .irq_req     (irq_req),
    .irq_mask    (irq_mask),
    .src_data    (src_data),
    .rti_done    (rti_done),
    .int_o       (int_o),
    .In_Port     (In_Port),
    .active_id   (active_id),
    .busy        (busy),
    .pending     (pending),
    .overrun     (overrun),
    .timeout_err (timeout_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_for_int(input string name, input int budget);
    int n;
    n = 0;
    while (int_o !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    chk({name, " int rise"}, int_o, 1);
  endtask

  task automatic pulse_width(output int w);
    w = 0;
    while (int_o === 1'b1 && w < 20) begin
      w++;
      tick();
    end
  endtask

  task automatic finish_service();
    rti_done = 1'b1;
    tick();
    rti_done = 1'b0;
    tick();
  endtask

  // Per-cycle vector table for the basic service scenario.
  typedef struct {
    logic [3:0]  req;
    logic        rti;
    logic        ex_int;
    logic        ex_busy;
    logic [3:0]  ex_pend;
    logic [15:0] ex_port;
    logic [2:0]  ex_id;
  } vec_t;

  vec_t tbl [16];
  int   ntbl = 0;

  task automatic add(input logic [3:0] req, input logic rti, input logic ei, input logic eb,
                     input logic [3:0] ep, input logic [15:0] eport, input logic [2:0] eid);
    tbl[ntbl].req     = req;
    tbl[ntbl].rti     = rti;
    tbl[ntbl].ex_int  = ei;
    tbl[ntbl].ex_busy = eb;
    tbl[ntbl].ex_pend = ep;
    tbl[ntbl].ex_port = eport;
    tbl[ntbl].ex_id   = eid;
    ntbl++;
  endtask

  // Reference model: service timeline counted from the moment selection begins.
  int          m_pend [NS];
  int          m_ovr  [NS];
  int          m_prev [NS];
  logic [15:0] m_data [NS];
  int          m_t, m_end, m_id, m_to;
  logic [15:0] m_port;

  function automatic int lowest(input int m);
    for (int i = 0; i < NS; i++) if (m[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NS; i++) begin
      m_pend[i] = 0; m_ovr[i] = 0; m_prev[i] = 0; m_data[i] = 16'h0;
    end
    m_t = -1; m_end = -1; m_id = 0; m_to = 0; m_port = 16'h0;
  endtask

  task automatic model_step();
    int elig;
    int c;
    logic rise;
    elig = 0;
    c = -1;
    for (int i = 0; i < NS; i++) if (m_pend[i] != 0 && irq_mask[i]) elig |= (1 << i);
    m_to = 0;
    if (m_t < 0) begin
      if (elig != 0) begin
        m_t = 0; m_id = lowest(elig); m_port = m_data[m_id];
      end
    end else if (m_t == 0) begin
      if (elig == 0) m_t = -1;
      else begin
        m_id = lowest(elig); m_port = m_data[m_id]; c = m_id; m_t = 1;
      end
    end else if (m_end < 0) begin
      if (m_t > P && (rti_done || (m_t - P) == TO)) begin
        m_to = rti_done ? 0 : 1;
        m_end = m_t + 1;
      end
      m_t++;
    end else begin
      if (m_t - m_end + 1 == G) begin
        m_t = -1; m_end = -1;
      end else m_t++;
    end
    for (int i = 0; i < NS; i++) begin
      rise = irq_req[i] && (m_prev[i] == 0);
      if (rise && m_pend[i] != 0 && i != c) m_ovr[i] = 1;
      else if (rise) begin
        m_pend[i] = 1; m_data[i] = src_data[16*i +: 16];
      end else if (i == c) m_pend[i] = 0;
      if (i == c) m_ovr[i] = 0;
      m_prev[i] = irq_req[i] ? 1 : 0;
    end
  endtask

  task automatic model_compare();
    logic [3:0] ep, eo;
    for (int i = 0; i < NS; i++) begin
      ep[i] = (m_pend[i] != 0);
      eo[i] = (m_ovr[i] != 0);
    end
    chk("rnd int", int_o, (m_t >= 1 && m_t <= P) ? 1 : 0);
    chk("rnd busy", busy, (m_t >= 0) ? 1 : 0);
    chk("rnd In_Port", In_Port, (m_t >= 0 && m_end < 0) ? m_port : 16'h0);
    chk("rnd pending", pending, ep);
    chk("rnd overrun", overrun, eo);
    chk("rnd timeout_err", timeout_err, m_to);
    chk("rnd active_id", active_id, m_id);
  endtask

  initial begin
    int w, n, highs;
    reset    = 1'b1;
    irq_req  = '0;
    irq_mask = '1;
    src_data = '0;
    rti_done = 1'b0;
    tick();
    tick();
    chk("reset int", int_o, 0);
    chk("reset In_Port", In_Port, 0);
    chk("reset active_id", active_id, 0);
    chk("reset busy", busy, 0);
    chk("reset pending", pending, 0);
    chk("reset overrun", overrun, 0);
    chk("reset timeout_err", timeout_err, 0);
    reset = 1'b0;

    // Basic service on source 1.
    src_data[31:16] = 16'hBEEF;
    add(4'b0000, 0, 0, 0, 4'b0000, 16'h0000, 0);
    add(4'b0010, 0, 0, 0, 4'b0010, 16'h0000, 0);
    add(4'b0000, 0, 0, 1, 4'b0010, 16'hBEEF, 1);
    add(4'b0000, 0, 1, 1, 4'b0000, 16'hBEEF, 1);
    add(4'b0000, 0, 1, 1, 4'b0000, 16'hBEEF, 1);
    for (int k = 0; k < 5; k++) add(4'b0000, 0, 0, 1, 4'b0000, 16'hBEEF, 1);
    add(4'b0000, 1, 0, 1, 4'b0000, 16'h0000, 1);
    add(4'b0000, 0, 0, 0, 4'b0000, 16'h0000, 1);
    for (int k = 0; k < ntbl; k++) begin
      irq_req  = tbl[k].req;
      rti_done = tbl[k].rti;
      tick();
      chk($sformatf("vec%0d int", k), int_o, tbl[k].ex_int);
      chk($sformatf("vec%0d busy", k), busy, tbl[k].ex_busy);
      chk($sformatf("vec%0d pending", k), pending, tbl[k].ex_pend);
      chk($sformatf("vec%0d In_Port", k), In_Port, tbl[k].ex_port);
      chk($sformatf("vec%0d active_id", k), active_id, tbl[k].ex_id);
    end
    rti_done = 1'b0;

    // Priority: sources 0 and 2 rise together.
    src_data[15:0]  = 16'hA000;
    src_data[47:32] = 16'hC222;
    irq_req = 4'b0101;
    tick();
    irq_req = 4'b0000;
    wait_for_int("prio first", 10);
    chk("prio first id", active_id, 0);
    chk("prio first data", In_Port, 16'hA000);
    pulse_width(w);
    chk("prio first width", w, P);
    rti_done = 1'b1;
    tick();
    rti_done = 1'b0;
    wait_for_int("prio second", 10);
    chk("prio second id", active_id, 2);
    chk("prio second data", In_Port, 16'hC222);
    pulse_width(w);
    chk("prio second width", w, P);
    finish_service();
    chk("prio idle", busy, 0);

    // Overrun: two edges on source 3 while it is masked.
    irq_mask = 4'b0111;
    src_data[63:48] = 16'h0001;
    irq_req = 4'b1000; tick();
    irq_req = 4'b0000; tick();
    src_data[63:48] = 16'h0002;
    irq_req = 4'b1000; tick();
    irq_req = 4'b0000; tick();
    chk("ovr flag", overrun[3], 1);
    chk("ovr pending", pending[3], 1);
    irq_mask = 4'b1111;
    wait_for_int("ovr", 10);
    chk("ovr served data", In_Port, 16'h0001);
    chk("ovr id", active_id, 3);
    chk("ovr cleared", overrun[3], 0);
    pulse_width(w);
    finish_service();

    // Mask: source 0 pending but ineligible.
    irq_mask = 4'b1110;
    irq_req = 4'b0001; tick();
    irq_req = 4'b0000;
    highs = 0;
    for (int k = 0; k < 50; k++) begin
      tick();
      if (int_o === 1'b1) highs++;
    end
    chk("mask int stays low", highs, 0);
    chk("mask pending", pending[0], 1);
    irq_mask = 4'b1111;
    tick();
    chk("unmask +1 int", int_o, 0);
    tick();
    chk("unmask +2 int", int_o, 1);
    pulse_width(w);
    finish_service();

    // Watchdog: no rti_done.
    irq_req = 4'b0010; tick();
    irq_req = 4'b0000;
    wait_for_int("wdog", 10);
    pulse_width(w);
    n = 0;
    while (timeout_err !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("wdog cycles", n, TO);
    chk("wdog gap busy", busy, 1);
    tick();
    chk("wdog pulse one cycle", timeout_err, 0);
    chk("wdog idle", busy, 0);
    rti_done = 1'b1; tick(); rti_done = 1'b0;
    chk("late rti busy", busy, 0);
    tick();
    chk("late rti int", int_o, 0);

    // Reset during ASSERT with request held high.
    irq_req = 4'b0100;
    wait_for_int("rst pre", 10);
    #2 reset = 1'b1;
    #1;
    chk("rst async int", int_o, 0);
    chk("rst async In_Port", In_Port, 0);
    chk("rst async pending", pending, 0);
    chk("rst async busy", busy, 0);
    tick();
    tick();
    reset = 1'b0;
    tick();
    chk("rst clk1 int", int_o, 0);
    tick();
    chk("rst clk2 int", int_o, 0);
    tick();
    chk("rst clk3 int", int_o, 1);
    irq_req = 4'b0000;
    pulse_width(w);
    finish_service();

    // Randomised run against the reference model.
    reset = 1'b1;
    irq_req = '0; irq_mask = '1; rti_done = 1'b0; src_data = '0;
    tick();
    reset = 1'b0;
    model_reset();
    for (int k = 0; k < 1500; k++) begin
      for (int i = 0; i < NS; i++) if ($urandom_range(7) == 0) irq_req[i] = ~irq_req[i];
      if ($urandom_range(31) == 0) irq_mask = 4'($urandom_range(15));
      rti_done = ($urandom_range(5) == 0);
      src_data = {$urandom, $urandom};
      model_step();
      tick();
      model_compare();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
